// File: rtl/fifo_packet_reader.sv
// Pops length-prefixed packets from a synchronous FIFO, drops the header word and
// streams the payload with sop/eop markers through a single output register.
module fifo_packet_reader #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_sop,
  output logic                 m_eop,
  output logic                 err_zero_len,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic                 fsm_state
);

  typedef enum logic {IDLE = 1'b0, PAYLOAD = 1'b1} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 first;
  logic                 space;
  logic                 handshake;
  logic [LEN_WIDTH-1:0] hdr_len;

  // Stream handshake: a word moves when m_valid && m_ready at a rising edge;
  // m_valid never drops and m_data/m_sop/m_eop never change while unaccepted.
  assign space     = !m_valid || m_ready;
  assign handshake = m_valid && m_ready;
  assign hdr_len   = fifo_data[LEN_WIDTH-1:0];

  // Header pops ignore output space; payload pops need a free output slot.
  assign fifo_rd_en = !rst && !fifo_empty && ((state == IDLE) || space);

  assign busy      = (state == PAYLOAD) || m_valid;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      first        <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_sop        <= 1'b0;
      m_eop        <= 1'b0;
      err_zero_len <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      err_zero_len <= 1'b0;
      if (handshake) begin
        m_valid <= 1'b0;
        if (m_eop) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (fifo_rd_en) begin
            if (hdr_len == '0) begin
              err_zero_len <= 1'b1;
            end else begin
              remaining <= hdr_len;
              first     <= 1'b1;
              state     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          // A pop here overrides the clear above, giving bubble-free reload.
          if (fifo_rd_en) begin
            m_data    <= fifo_data;
            m_valid   <= 1'b1;
            m_sop     <= first;
            m_eop     <= (remaining == LEN_WIDTH'(1));
            first     <= 1'b0;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Directed bench for fifo_packet_reader: a queue-modelled FIFO feeds packets and a
// scoreboard compares every accepted stream word against the expected sequence.
module tb_fifo_packet_reader;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_sop;
  logic          m_eop;
  logic          err_zero_len;
  logic          busy;
  logic [15:0]   pkt_cnt;
  logic          fsm_state;

  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  fifo_head;
  logic [W+1:0]  exp_q[$];
  logic [W+1:0]  exp_word;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_pkts = 0;
  int pop_cnt, first_pop, last_pop;
  int hs_cnt, first_hs, last_hs;
  int err_cnt;

  fifo_packet_reader #(.WIDTH(W), .LEN_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .err_zero_len(err_zero_len),
    .busy(busy), .pkt_cnt(pkt_cnt), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // FIFO model: read data is only meaningful in a popping cycle, garbage otherwise.
  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_head  = fifo_empty ? '0 : fifo_q[0];
  endtask

  always_comb fifo_data = (fifo_rd_en && !fifo_empty) ? fifo_head : 8'hEE;

  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en && !fifo_empty) begin
      void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  task automatic expect_word(input logic sop, input logic eop, input logic [W-1:0] d);
    exp_q.push_back({sop, eop, d});
  endtask

  task automatic clear_stats();
    pop_cnt = 0; first_pop = 0; last_pop = 0;
    hs_cnt = 0; first_hs = 0; last_hs = 0;
    err_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size() == 0 && fifo_q.size() == 0 && !busy), 32'd1);
  endtask

  // scoreboard / monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    if (err_zero_len) err_cnt++;
    if (!rst && m_valid && m_ready) begin
      if (hs_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      hs_cnt++;
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check("stream_word", 32'({m_sop, m_eop, m_data}), 32'(exp_word));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    m_ready = 1'b0;
    clear_stats();
    fifo_refresh();

    // reset state, then idle with an empty FIFO
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", 32'({m_valid, m_sop, m_eop, err_zero_len, busy, fifo_rd_en, fsm_state}), 32'd0);
    check("reset_data_cnt", 32'({m_data, pkt_cnt}), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({m_valid, m_sop, m_eop, err_zero_len, busy, fifo_rd_en, m_data, pkt_cnt}), 32'd0);
    end

    // 3-word packet, full throughput
    step();
    clear_stats();
    m_ready = 1'b1;
    push_word(8'h03); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    expect_word(1'b1, 1'b0, 8'hA1); expect_word(1'b0, 1'b0, 8'hA2); expect_word(1'b0, 1'b1, 8'hA3);
    exp_pkts++;
    wait_done("t2_drain");
    check("t2_pop_cnt", 32'(pop_cnt), 32'd4);
    check("t2_pop_span", 32'(last_pop - first_pop), 32'd3);
    check("t2_hs_cnt", 32'(hs_cnt), 32'd3);
    check("t2_first_out_lat", 32'(first_hs - first_pop), 32'd2);
    check("t2_out_span", 32'(last_hs - first_hs), 32'd2);
    check("t2_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

    // backpressure while 0xA2 is presented
    step();
    clear_stats();
    push_word(8'h03); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    expect_word(1'b1, 1'b0, 8'hA1); expect_word(1'b0, 1'b0, 8'hA2); expect_word(1'b0, 1'b1, 8'hA3);
    exp_pkts++;
    n = 0;
    @(negedge clk);
    while (!(m_valid && m_data == 8'hA1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_a1_seen", 32'(m_valid && m_data == 8'hA1), 32'd1);
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_word", 32'({m_valid, m_sop, m_eop, m_data}), 32'({3'b100, 8'hA2}));
      check("t3_hold_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    step();
    m_ready = 1'b1;
    wait_done("t3_drain");
    check("t3_hs_cnt", 32'(hs_cnt), 32'd3);
    check("t3_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

    // zero-length header followed by a 1-word packet
    step();
    clear_stats();
    push_word(8'h00); push_word(8'h01); push_word(8'h55);
    expect_word(1'b1, 1'b1, 8'h55);
    exp_pkts++;
    wait_done("t4_drain");
    check("t4_err_pulses", 32'(err_cnt), 32'd1);
    check("t4_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

    // upper header bits ignored; FIFO runs dry mid-packet
    step();
    clear_stats();
    push_word(8'hF2); push_word(8'h11);
    expect_word(1'b1, 1'b0, 8'h11); expect_word(1'b0, 1'b1, 8'h22);
    exp_pkts++;
    n = 0;
    @(negedge clk);
    while (hs_cnt < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_word", 32'(hs_cnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("t5_busy", 32'({busy, fsm_state}), 32'b11);
    end
    step();
    push_word(8'h22);
    wait_done("t5_drain");
    check("t5_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

    // two 1-word packets back to back
    step();
    clear_stats();
    push_word(8'h01); push_word(8'h7E); push_word(8'h01); push_word(8'h7F);
    expect_word(1'b1, 1'b1, 8'h7E); expect_word(1'b1, 1'b1, 8'h7F);
    exp_pkts += 2;
    wait_done("t6_drain");
    check("t6_pop_cnt", 32'(pop_cnt), 32'd4);
    check("t6_pop_span", 32'(last_pop - first_pop), 32'd3);
    check("t6_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

    // reset mid-packet with words still in the FIFO
    step();
    clear_stats();
    m_ready = 1'b0;
    push_word(8'h03); push_word(8'h61); push_word(8'h62);
    repeat (4) @(negedge clk);
    check("t7_stalled", 32'({m_valid, m_data, fifo_rd_en}), 32'({1'b1, 8'h61, 1'b0}));
    step();
    rst = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("t7_rst_rd_en", 32'({fifo_empty, fifo_rd_en}), 32'd0);
    step();
    fifo_q.delete();
    fifo_refresh();
    @(negedge clk);
    check("t7_reset_state", 32'({m_valid, m_sop, m_eop, busy, fsm_state, pkt_cnt}), 32'd0);
    step();
    rst = 1'b0;
    clear_stats();
    exp_pkts = 1;
    push_word(8'h01); push_word(8'h5A);
    expect_word(1'b1, 1'b1, 8'h5A);
    wait_done("t7_drain");
    check("t7_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
